uart_rx_fifo: RTL and testbench

//  Board-level UART receiver between the RX pin (ICE_27) and the core logic.
//  - Synchronises the async serial line and decodes 8N1 frames, LSB first.
//  - Buffers received bytes in a small FWFT FIFO.
//  - Presents bytes on a valid/ready stream to the PipelineC core.
//  - Runs entirely in the PLL output domain clk_100p0.

---
 rtl/uart_rx_fifo.sv | 254 +++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a small FWFT FIFO
// that is drained over a valid/ready stream; single clock clk_100p0, synchronous active-high rst.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk_100p0,
  input  logic       rst,
  input  logic       rx_pin,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       parity_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 32'sd2 - 32'sd1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 32'sd1);
  localparam logic [AW:0]   PTR_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   PTR_ONE  = {{AW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_t;

  logic [1:0]    sync_r;
  logic          rxs_s;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic [2:0]    idx_r;
  logic [2:0]    idx_nxt_s;
  logic [7:0]    shift_r;
  logic [7:0]    shift_nxt_s;
  logic          push_s;
  logic          frame_s;
  logic          parity_s;

`ifdef UART_RX_PARITY_EN
  logic          par_r;
  logic          par_nxt_s;

  function automatic logic parity8(input logic [7:0] data);
    return ^data;
  endfunction
`endif

  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic [AW:0]   wr_ptr_nxt_s;
  logic [AW:0]   rd_ptr_nxt_s;
  logic          full_s;
  logic          rd_en_s;
  logic          wr_en_s;
  logic          overrun_s;
  logic [7:0]    head_nxt_s;

  assign rxs_s = sync_r[1];

  // Two-flop synchroniser for the asynchronous line, idling high
  always_ff @(posedge clk_100p0) begin
    if (rst) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rx_pin};
    end
  end

  // Receiver state, bit timer, bit index and assembled byte
  always_ff @(posedge clk_100p0) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
`ifdef UART_RX_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
      shift_r <= shift_nxt_s;
`ifdef UART_RX_PARITY_EN
      par_r   <= par_nxt_s;
`endif
    end
  end

  // Frame decoder: half-bit timer from start edge, then full-bit timer to land on bit centres
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    idx_nxt_s   = idx_r;
    shift_nxt_s = shift_r;
    push_s      = 1'b0;
    frame_s     = 1'b0;
    parity_s    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_nxt_s   = par_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (!rxs_s) begin
          state_nxt_s = ST_START;
          cnt_nxt_s   = CNT_HALF;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_r == CNT_ZERO) begin
          if (!rxs_s) begin
            state_nxt_s = ST_DATA;
            cnt_nxt_s   = CNT_FULL;
            idx_nxt_s   = 3'd0;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      ST_DATA: begin
        if (cnt_r == CNT_ZERO) begin
          shift_nxt_s[idx_r] = rxs_s;
          cnt_nxt_s          = CNT_FULL;
          if (idx_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt_s = ST_PARITY;
`else
            state_nxt_s = ST_STOP;
`endif
          end else begin
            idx_nxt_s = idx_r + 3'd1;
          end
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_r == CNT_ZERO) begin
          par_nxt_s   = rxs_s;
          cnt_nxt_s   = CNT_FULL;
          state_nxt_s = ST_STOP;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_r == CNT_ZERO) begin
          if (rxs_s) begin
            state_nxt_s = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            // Even parity: data and parity bit together must XOR to zero
            if (parity8(shift_r) ^ par_r) begin
              parity_s = 1'b1;
            end else begin
              push_s = 1'b1;
            end
`else
            push_s = 1'b1;
`endif
          end else begin
            frame_s     = 1'b1;
            state_nxt_s = ST_BREAK;
          end
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      ST_BREAK: begin
        if (rxs_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BREAK;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // FIFO control; a pop in the same cycle frees the slot a full-FIFO push needs
  always_comb begin
    full_s       = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    rd_en_s      = m_valid && m_ready;
    wr_en_s      = push_s && (!full_s || rd_en_s);
    overrun_s    = push_s && full_s && !rd_en_s;
    wr_ptr_nxt_s = wr_en_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
    rd_ptr_nxt_s = rd_en_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
    if (wr_en_s && (wr_ptr_r[AW-1:0] == rd_ptr_nxt_s[AW-1:0])) begin
      head_nxt_s = shift_r;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s[AW-1:0]];
    end
  end

  // FIFO pointers and storage
  always_ff @(posedge clk_100p0) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      if (wr_en_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= shift_r;
      end
    end
  end

  // Registered stream and status outputs, pre-computed from next-cycle FIFO state
  always_ff @(posedge clk_100p0) begin
    if (rst) begin
      m_valid     <= 1'b0;
      m_data      <= 8'h00;
      rx_busy     <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      parity_err  <= 1'b0;
    end else begin
      m_valid <= (wr_ptr_nxt_s != rd_ptr_nxt_s);
      if (wr_ptr_nxt_s != rd_ptr_nxt_s) begin
        m_data <= head_nxt_s;
      end
      rx_busy     <= (state_nxt_s != ST_IDLE);
      frame_err   <= frame_s;
      overrun_err <= overrun_s;
      parity_err  <= parity_s;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (CLKS_PER_BIT=16, FIFO_DEPTH=4): directed scenarios plus
// randomized frames checked against a queue-based model of the received byte stream.
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_pin;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun_err;
  logic       parity_err;

  int total = 0;
  int bad   = 0;

  logic [7:0] got_q[$];
  int n_valid   = 0;
  int n_frame   = 0;
  int n_over    = 0;
  int n_par     = 0;
  int n_overlap = 0;
  int n_wide    = 0;
  logic fe_d = 1'b0;
  logic oe_d = 1'b0;
  logic pe_d = 1'b0;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk_100p0  (clk),
    .rst        (rst),
    .rx_pin     (rx_pin),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .overrun_err(overrun_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  // Observe the stream and error pulses on the inactive edge
  always @(negedge clk) begin
    if (m_valid === 1'b1) n_valid++;
    if (m_valid === 1'b1 && m_ready === 1'b1) got_q.push_back(m_data);
    if (frame_err === 1'b1) n_frame++;
    if (overrun_err === 1'b1) n_over++;
    if (parity_err === 1'b1) n_par++;
    if ((int'(frame_err) + int'(overrun_err) + int'(parity_err)) > 1) n_overlap++;
    if ((frame_err && fe_d) || (overrun_err && oe_d) || (parity_err && pe_d)) n_wide++;
    fe_d = frame_err;
    oe_d = overrun_err;
    pe_d = parity_err;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    n_valid   = 0;
    n_frame   = 0;
    n_over    = 0;
    n_par     = 0;
    n_overlap = 0;
    n_wide    = 0;
  endtask

  task automatic send_raw(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      rx_pin = bits[i];
      tick(CPB);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
`ifdef UART_RX_PARITY_EN
    send_raw({1'b0, stop, ^d, d, 1'b0}, 11);
`else
    send_raw({2'b00, stop, d, 1'b0}, 10);
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_pin = 1'b1; m_ready = 1'b0;
    tick(3);
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%0h exp=0", m_valid); end
    total++; if (m_data !== 8'h00) begin bad++; $display("FAIL reset_m_data got=%0h exp=0", m_data); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL reset_rx_busy got=%0h exp=0", rx_busy); end
    total++; if ({frame_err, overrun_err, parity_err} !== 3'b000) begin
      bad++; $display("FAIL reset_errs got=%0b exp=000", {frame_err, overrun_err, parity_err});
    end
    rst = 1'b0;
    tick(2);
    clear_mon();
  endtask

  task automatic test_single();
    m_ready = 1'b1;
    clear_mon();
    send_frame(8'hA5, 1'b1);
    tick(4);
    total++; if (got_q.size() !== 1) begin bad++; $display("FAIL single_count got=%0d exp=1", got_q.size()); end
    total++; if (got_q.size() > 0 && got_q[0] !== 8'hA5) begin bad++; $display("FAIL single_data got=%0h exp=a5", got_q[0]); end
    total++; if (n_valid !== 1) begin bad++; $display("FAIL single_valid_cycles got=%0d exp=1", n_valid); end
    total++; if (n_frame + n_over + n_par !== 0) begin
      bad++; $display("FAIL single_errs got=%0d exp=0", n_frame + n_over + n_par);
    end
  endtask

  task automatic test_overrun();
    m_ready = 1'b0;
    clear_mon();
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    tick(2);
    total++; if (n_over !== 1) begin bad++; $display("FAIL overrun_pulses got=%0d exp=1", n_over); end
    total++; if (n_wide !== 0) begin bad++; $display("FAIL overrun_width got=%0d exp=0", n_wide); end
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL overrun_full_valid got=%0h exp=1", m_valid); end
    m_ready = 1'b1;
    tick(8);
    m_ready = 1'b0;
    tick(1);
    total++; if (got_q.size() !== 4) begin bad++; $display("FAIL overrun_pop_count got=%0d exp=4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== 8'(i + 1)) begin
        bad++; $display("FAIL overrun_order idx=%0d got=%0h exp=%0h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, 8'(i + 1));
      end
    end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL overrun_drained got=%0h exp=0", m_valid); end
  endtask

  task automatic test_frame_err();
    m_ready = 1'b1;
    clear_mon();
    send_frame(8'h3C, 1'b0);
    tick(100);
    total++; if (n_frame !== 1) begin bad++; $display("FAIL frame_pulses got=%0d exp=1", n_frame); end
    total++; if (got_q.size() !== 0) begin bad++; $display("FAIL frame_no_push got=%0d exp=0", got_q.size()); end
    total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL frame_break_busy got=%0h exp=1", rx_busy); end
    rx_pin = 1'b1;
    tick(4);
    send_frame(8'h55, 1'b1);
    tick(4);
    total++; if (got_q.size() !== 1 || got_q[0] !== 8'h55) begin
      bad++; $display("FAIL frame_recover got_count=%0d exp_count=1 exp=55", got_q.size());
    end
    total++; if (n_frame !== 1 || n_wide !== 0) begin
      bad++; $display("FAIL frame_after got=%0d/%0d exp=1/0", n_frame, n_wide);
    end
  endtask

  task automatic test_glitch();
    m_ready = 1'b1;
    clear_mon();
    rx_pin = 1'b0;
    tick(4);
    rx_pin = 1'b1;
    total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_rise got=%0h exp=1", rx_busy); end
    tick(CPB);
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_fall got=%0h exp=0", rx_busy); end
    total++; if (got_q.size() !== 0 || n_frame + n_over + n_par !== 0) begin
      bad++; $display("FAIL glitch_quiet got=%0d/%0d exp=0/0", got_q.size(), n_frame + n_over + n_par);
    end
  endtask

  task automatic test_reset_mid_frame();
    m_ready = 1'b0;
    clear_mon();
    send_frame(8'h11, 1'b1);
    send_raw({2'b00, 1'b1, 8'hFF, 1'b0}, 5);
    rx_pin = 1'b1;
    tick(CPB / 2);
    rst = 1'b1;
    tick(1);
    total++; if ({m_valid, rx_busy, frame_err, overrun_err, parity_err} !== 5'b00000) begin
      bad++; $display("FAIL midrst_flags got=%0b exp=00000", {m_valid, rx_busy, frame_err, overrun_err, parity_err});
    end
    total++; if (m_data !== 8'h00) begin bad++; $display("FAIL midrst_m_data got=%0h exp=0", m_data); end
    rst = 1'b0;
    m_ready = 1'b1;
    tick(2 * CPB);
    clear_mon();
    send_frame(8'h7E, 1'b1);
    tick(4);
    total++; if (got_q.size() !== 1 || got_q[0] !== 8'h7E) begin
      bad++; $display("FAIL midrst_recv got_count=%0d exp_count=1 exp=7e", got_q.size());
    end
  endtask

  task automatic test_random();
    logic [7:0] model_q[$];
    logic [7:0] d;
    int exp_frame;
    int exp_over;
    int guard;
    int n;
    logic bad_stop;
    for (int r = 0; r < 4; r++) begin
      model_q.delete();
      exp_frame = 0;
      exp_over  = 0;
      m_ready   = 1'b0;
      clear_mon();
      n = $urandom_range(1, 7);
      for (int k = 0; k < n; k++) begin
        d = 8'($urandom);
        bad_stop = ($urandom_range(0, 5) == 0);
        send_frame(d, !bad_stop);
        if (bad_stop) begin
          exp_frame++;
          rx_pin = 1'b1;
          tick(3);
        end else if (model_q.size() < DEPTH) begin
          model_q.push_back(d);
        end else begin
          exp_over++;
        end
        tick($urandom_range(0, 5));
      end
      guard = 0;
      while (got_q.size() < model_q.size() && guard < 400) begin
        m_ready = 1'($urandom_range(0, 1));
        tick(1);
        guard++;
      end
      m_ready = 1'b0;
      tick(3);
      total++; if (guard >= 400) begin bad++; $display("FAIL rand_drain_timeout round=%0d got=%0d exp=%0d", r, got_q.size(), model_q.size()); end
      total++; if (got_q.size() !== model_q.size()) begin
        bad++; $display("FAIL rand_count round=%0d got=%0d exp=%0d", r, got_q.size(), model_q.size());
      end
      for (int i = 0; i < model_q.size(); i++) begin
        total++;
        if (i >= got_q.size() || got_q[i] !== model_q[i]) begin
          bad++; $display("FAIL rand_data round=%0d idx=%0d got=%0h exp=%0h", r, i, (i < got_q.size()) ? got_q[i] : 8'hxx, model_q[i]);
        end
      end
      total++; if (n_frame !== exp_frame || n_over !== exp_over) begin
        bad++; $display("FAIL rand_errs round=%0d got=%0d/%0d exp=%0d/%0d", r, n_frame, n_over, exp_frame, exp_over);
      end
      total++; if (n_overlap !== 0 || n_wide !== 0 || m_valid !== 1'b0) begin
        bad++; $display("FAIL rand_pulse_shape round=%0d got=%0d/%0d/%0h exp=0/0/0", r, n_overlap, n_wide, m_valid);
      end
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    m_ready = 1'b1;
    clear_mon();
    send_frame(8'h03, 1'b1);
    tick(4);
    total++; if (got_q.size() !== 1 || got_q[0] !== 8'h03 || n_par !== 0) begin
      bad++; $display("FAIL parity_good got_count=%0d par=%0d exp=1/0", got_q.size(), n_par);
    end
    clear_mon();
    send_raw({1'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
    tick(4);
    total++; if (n_par !== 1 || n_valid !== 0 || n_frame !== 0) begin
      bad++; $display("FAIL parity_bad got=%0d/%0d/%0d exp=1/0/0", n_par, n_valid, n_frame);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    rx_pin = 1'b1;
    m_ready = 1'b0;
    test_reset();
    test_single();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_reset_mid_frame();
    test_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
